// File: rtl/lbm_step_scheduler.sv
// lbm_step_scheduler
// Top-level sequencer for the D2Q9 lattice datapath. Each time step it kicks
// one collide/stream sweep of the compute engine, waits for completion, then
// flips the ping-pong bank. Every div-th step it hands the BRAM read port to
// the AXI-Stream frame dumper and waits for the frame to drain. Both wait
// phases are covered by a watchdog that parks the block in a sticky ERROR.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, stop       run request pulse / stop request pulse (honoured at step boundary)
//   cfg_frame_div     steps per dumped frame (0 behaves as 1), latched at start
//   cmp_start/done    sweep handshake with the compute engine
//   dump_start/done   frame handshake with the dumper
//   cmp_addr/dump_addr, bram_rd_addr   read-address sources and muxed BRAM address
//   grant_dump        read-port owner (1 = dumper)
//   rd_bank           bank holding current valid data
//   busy, err         activity flag, sticky watchdog error
//   step_count, frame_count   completed steps / frames since start
module lbm_step_scheduler #(
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12,
  parameter int TIMEOUT       = 65535,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [7:0]               cfg_frame_div,
  output logic                     cmp_start,
  input  logic                     cmp_done,
  input  logic [ADDRESS_WIDTH-1:0] cmp_addr,
  output logic                     dump_start,
  input  logic                     dump_done,
  input  logic [ADDRESS_WIDTH-1:0] dump_addr,
  output logic [ADDRESS_WIDTH-1:0] bram_rd_addr,
  output logic                     grant_dump,
  output logic                     rd_bank,
  output logic                     busy,
  output logic                     err,
  output logic [CNT_WIDTH-1:0]     step_count,
  output logic [CNT_WIDTH-1:0]     frame_count
);

  // Watchdog just wide enough to hold TIMEOUT-1.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  // Refuse to elaborate if a frame cannot be addressed.
  if (DEPTH > (1 << ADDRESS_WIDTH)) begin : g_depth_check
    $error("DEPTH does not fit in ADDRESS_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CMP_START  = 3'd1,
    CMP_WAIT   = 3'd2,
    SWAP       = 3'd3,
    DUMP_START = 3'd4,
    DUMP_WAIT  = 3'd5,
    ERROR      = 3'd6
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [7:0]             div_r, div_cnt_r;
  logic [WD_W-1:0]        wd_r;
  logic                   stop_pending_r;
  logic                   cmp_start_r, dump_start_r, grant_dump_r, busy_r, err_r, rd_bank_r;
  logic [CNT_WIDTH-1:0]   step_count_r, frame_count_r;
  logic                   stop_eff_s, wd_expired_s, frame_due_s;

  // A stop arriving in the boundary cycle itself still counts.
  assign stop_eff_s   = stop_pending_r | stop;
  assign wd_expired_s = (wd_r == WD_MAX);
  assign frame_due_s  = (div_cnt_r == (div_r - 8'd1));

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:       if (start) state_nxt_s = CMP_START; else state_nxt_s = IDLE;
      CMP_START:  state_nxt_s = CMP_WAIT;
      CMP_WAIT: begin
        if (cmp_done)          state_nxt_s = SWAP;
        else if (wd_expired_s) state_nxt_s = ERROR;
        else                   state_nxt_s = CMP_WAIT;
      end
      SWAP: begin
        if (frame_due_s)     state_nxt_s = DUMP_START;
        else if (stop_eff_s) state_nxt_s = IDLE;
        else                 state_nxt_s = CMP_START;
      end
      DUMP_START: state_nxt_s = DUMP_WAIT;
      DUMP_WAIT: begin
        if (dump_done)         state_nxt_s = stop_eff_s ? IDLE : CMP_START;
        else if (wd_expired_s) state_nxt_s = ERROR;
        else                   state_nxt_s = DUMP_WAIT;
      end
      ERROR:      state_nxt_s = ERROR;
      default:    state_nxt_s = ERROR;
    endcase
  end

  // State register plus control outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cmp_start_r  <= 1'b0;
      dump_start_r <= 1'b0;
      grant_dump_r <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cmp_start_r  <= (state_nxt_s == CMP_START);
      dump_start_r <= (state_nxt_s == DUMP_START);
      grant_dump_r <= (state_nxt_s == DUMP_START) || (state_nxt_s == DUMP_WAIT);
      busy_r       <= (state_nxt_s != IDLE);
      err_r        <= (state_nxt_s == ERROR);
    end
  end

  // Run configuration, step/frame counters and bank toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r         <= 8'd0;
      div_cnt_r     <= 8'd0;
      step_count_r  <= '0;
      frame_count_r <= '0;
      rd_bank_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            div_r         <= (cfg_frame_div == 8'd0) ? 8'd1 : cfg_frame_div;
            div_cnt_r     <= 8'd0;
            step_count_r  <= '0;
            frame_count_r <= '0;
          end
        end
        SWAP: begin
          rd_bank_r    <= ~rd_bank_r;
          step_count_r <= step_count_r + CNT_WIDTH'(1);
          div_cnt_r    <= frame_due_s ? 8'd0 : (div_cnt_r + 8'd1);
        end
        DUMP_WAIT: begin
          if (dump_done) frame_count_r <= frame_count_r + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Watchdog and deferred stop request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_r           <= '0;
      stop_pending_r <= 1'b0;
    end else begin
      if ((state_r == CMP_START) || (state_r == DUMP_START)) begin
        wd_r <= '0;
      end else if (((state_r == CMP_WAIT) && !cmp_done) ||
                   ((state_r == DUMP_WAIT) && !dump_done)) begin
        wd_r <= wd_r + WD_W'(1);
      end else begin
        wd_r <= wd_r;
      end

      if ((state_r == IDLE) || (state_nxt_s == IDLE)) begin
        stop_pending_r <= 1'b0;
      end else if (stop && (state_r != ERROR)) begin
        stop_pending_r <= 1'b1;
      end else begin
        stop_pending_r <= stop_pending_r;
      end
    end
  end

  // Read-port mux follows the registered grant so the switch is glitch-free.
  assign bram_rd_addr = grant_dump_r ? dump_addr : cmp_addr;

  assign cmp_start   = cmp_start_r;
  assign dump_start  = dump_start_r;
  assign grant_dump  = grant_dump_r;
  assign rd_bank     = rd_bank_r;
  assign busy        = busy_r;
  assign err         = err_r;
  assign step_count  = step_count_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_lbm_step_scheduler.sv
// Testbench for lbm_step_scheduler: table-driven step sequences for the
// normal run (div=3 and div=0), plus directed sequences for reset during a
// dump, stop coinciding with cmp_done, and the watchdog (TIMEOUT=16 instance).
module tb_lbm_step_scheduler;

  localparam int AW = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, stop, cmp_done, dump_done;
  logic [7:0]    cfg;
  logic [AW-1:0] cmp_addr, dump_addr;

  logic          cmp_start, dump_start, grant_dump, rd_bank, busy, err;
  logic [AW-1:0] bram_rd_addr;
  logic [CW-1:0] step_count, frame_count;

  logic          w_cmp_start, w_dump_start, w_grant_dump, w_rd_bank, w_busy, w_err;
  logic [AW-1:0] w_bram_rd_addr;
  logic [CW-1:0] w_step_count, w_frame_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lbm_step_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_frame_div(cfg),
    .cmp_start(cmp_start), .cmp_done(cmp_done), .cmp_addr(cmp_addr),
    .dump_start(dump_start), .dump_done(dump_done), .dump_addr(dump_addr),
    .bram_rd_addr(bram_rd_addr), .grant_dump(grant_dump), .rd_bank(rd_bank),
    .busy(busy), .err(err), .step_count(step_count), .frame_count(frame_count)
  );

  lbm_step_scheduler #(.TIMEOUT(16)) dut_wd (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_frame_div(cfg),
    .cmp_start(w_cmp_start), .cmp_done(cmp_done), .cmp_addr(cmp_addr),
    .dump_start(w_dump_start), .dump_done(dump_done), .dump_addr(dump_addr),
    .bram_rd_addr(w_bram_rd_addr), .grant_dump(w_grant_dump), .rd_bank(w_rd_bank),
    .busy(w_busy), .err(w_err), .step_count(w_step_count), .frame_count(w_frame_count)
  );

  typedef struct {
    logic        new_run;
    logic [7:0]  cfg;
    logic        exp_dump;
    logic        stop_now;
    logic        exp_bank;
    logic [15:0] exp_step;
    logic [15:0] exp_frame;
  } step_vec_t;

  step_vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // div=3 run: dumps after steps 3 and 6, stop during the second dump
    vecs[0] = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0};
    vecs[1] = '{1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0};
    vecs[2] = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b1, 16'd3, 16'd1};
    vecs[3] = '{1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 16'd4, 16'd1};
    vecs[4] = '{1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 16'd5, 16'd1};
    vecs[5] = '{1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 16'd6, 16'd2};
    // div=0 behaves as 1: dump after every step
    vecs[6] = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1};
    vecs[7] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd2};

    rst = 1'b1; start = 1'b0; stop = 1'b0; cmp_done = 1'b0; dump_done = 1'b0;
    cfg = 8'd0; cmp_addr = 12'h123; dump_addr = 12'h9C3;
    tick(3);
    rst = 1'b0;

    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_grant", grant_dump, 1'b0);
    chk("rst_bank", rd_bank, 1'b0);
    chk("rst_pulses", {cmp_start, dump_start}, 2'b00);
    chk("rst_counts", {step_count, frame_count}, 32'd0);
    chk("rst_mux", bram_rd_addr, 12'h123);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].new_run) begin
        cfg = vecs[i].cfg;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
      end
      chk("cmp_start_pulse", cmp_start, 1'b1);
      tick(1);
      chk("cmp_start_one_cycle", cmp_start, 1'b0);
      tick(9);
      chk("cmp_grant", grant_dump, 1'b0);
      chk("mux_cmp", bram_rd_addr, 12'h123);
      tick(10);
      cmp_done = 1'b1;
      tick(1);
      cmp_done = 1'b0;
      tick(1);
      chk("step_count", step_count, vecs[i].exp_step);
      chk("rd_bank", rd_bank, vecs[i].exp_bank);
      chk("dump_start", dump_start, vecs[i].exp_dump);
      if (vecs[i].exp_dump) begin
        chk("dump_grant", grant_dump, 1'b1);
        chk("mux_dump_start", bram_rd_addr, 12'h9C3);
        stop = vecs[i].stop_now;
        tick(1);
        stop = 1'b0;
        tick(29);
        chk("dump_wait_grant", grant_dump, 1'b1);
        chk("mux_dump_wait", bram_rd_addr, 12'h9C3);
        chk("dump_start_one_cycle", dump_start, 1'b0);
        dump_done = 1'b1;
        tick(1);
        dump_done = 1'b0;
        chk("grant_release", grant_dump, 1'b0);
      end
      chk("frame_count", frame_count, vecs[i].exp_frame);
      if (vecs[i].stop_now) begin
        chk("stop_idle_busy", busy, 1'b0);
        chk("stop_idle_no_cmp", cmp_start, 1'b0);
      end else begin
        chk("next_cmp_start", cmp_start, 1'b1);
      end
    end

    // Reset while a dump is in flight
    cfg = 8'd1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    cmp_done = 1'b1;
    tick(1);
    cmp_done = 1'b0;
    tick(1);
    chk("rstdump_dump_start", dump_start, 1'b1);
    chk("rstdump_bank_pre", rd_bank, 1'b1);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstdump_grant", grant_dump, 1'b0);
    chk("rstdump_busy", busy, 1'b0);
    chk("rstdump_bank", rd_bank, 1'b0);
    chk("rstdump_counts", {step_count, frame_count}, 32'd0);
    dump_done = 1'b1;
    tick(1);
    dump_done = 1'b0;
    tick(1);
    chk("stray_done_frame", frame_count, 16'd0);
    chk("stray_done_busy", busy, 1'b0);

    // stop together with cmp_done, div=2: finishes the step, no dump
    cfg = 8'd2;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("stopdone_cmp_start", cmp_start, 1'b1);
    tick(5);
    cmp_done = 1'b1;
    stop = 1'b1;
    tick(1);
    cmp_done = 1'b0;
    stop = 1'b0;
    chk("stopdone_in_swap", busy, 1'b1);
    tick(1);
    chk("stopdone_idle", busy, 1'b0);
    chk("stopdone_step", step_count, 16'd1);
    chk("stopdone_bank", rd_bank, 1'b1);
    chk("stopdone_no_dump", dump_start, 1'b0);
    tick(3);
    chk("stopdone_stays_idle", {busy, dump_start, cmp_start}, 3'b000);

    // Watchdog on the TIMEOUT=16 instance
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    cfg = 8'd1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("wd_cmp_start", w_cmp_start, 1'b1);
    tick(16);
    chk("wd_not_yet", w_err, 1'b0);
    tick(1);
    chk("wd_err", w_err, 1'b1);
    chk("wd_err_busy", w_busy, 1'b1);
    chk("wd_err_grant", w_grant_dump, 1'b0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("wd_start_ignored", w_cmp_start, 1'b0);
    chk("wd_err_sticky", w_err, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("wd_rst_err", w_err, 1'b0);
    chk("wd_rst_busy", w_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbm_step_scheduler.md
Name: lbm_step_scheduler

Overview:
- Top-level sequencer for the D2Q9 lattice datapath: runs one collide/stream sweep per time step over the DEPTH-cell distribution BRAMs, then toggles the ping-pong bank.
- Every cfg_frame_div steps, hands the BRAM read port to the AXI-Stream frame dumper and waits for the frame to complete.
- Owns the BRAM read-address mux between the compute engine and the dumper.
- Includes a watchdog on both phases.

Parameters:
DEPTH, 2500, cells per frame (50x50 lattice)
ADDRESS_WIDTH, 12, BRAM address width
TIMEOUT, 65535, max cycles allowed in any *_WAIT state before ERROR
CNT_WIDTH, 16, width of step/frame counters

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  run request pulse
stop  in  1  stop request pulse
cfg_frame_div  in  8  steps per dumped frame; 0 treated as 1
cmp_start  out  1  one-cycle pulse: begin one sweep
cmp_done  in  1  pulse: sweep finished
cmp_addr  in  ADDRESS_WIDTH  compute engine read address
dump_start  out  1  one-cycle pulse: begin frame dump (frame_ready of dumper)
dump_done  in  1  pulse: last beat (tlast & tready) accepted
dump_addr  in  ADDRESS_WIDTH  dumper read address
bram_rd_addr  out  ADDRESS_WIDTH  muxed BRAM read address
grant_dump  out  1  0 = compute owns read port, 1 = dumper owns it
rd_bank  out  1  bank holding current valid data; compute writes ~rd_bank
busy  out  1  high whenever state != IDLE
err  out  1  sticky watchdog error
step_count  out  CNT_WIDTH  completed steps since start
frame_count  out  CNT_WIDTH  completed frames since start

Behaviour:
- Reset values:
  - state IDLE
  - all pulses 0, grant_dump 0, rd_bank 0, busy 0, err 0
  - counters 0, stop_pending 0, watchdog 0
- States: IDLE, CMP_START, CMP_WAIT, SWAP, DUMP_START, DUMP_WAIT, ERROR.
- IDLE:
  - start=1 latches div = max(cfg_frame_div,1).
  - Clears step_count, frame_count, div_cnt, stop_pending.
  - Next state CMP_START.
  - stop is ignored in IDLE. rd_bank is not changed by start.
- CMP_START:
  - cmp_start=1 for exactly this cycle, grant_dump=0, watchdog cleared.
  - Next state CMP_WAIT.
  - Latency: start sampled at edge N gives cmp_start high in cycle N+1.
- CMP_WAIT:
  - cmp_done -> SWAP.
  - Otherwise watchdog+1; watchdog reaching TIMEOUT-1 -> ERROR.
- SWAP (one cycle):
  - rd_bank toggles, step_count+1 (wraps modulo 2^CNT_WIDTH).
  - If div_cnt==div-1: div_cnt=0, next DUMP_START.
  - Else div_cnt+1; next IDLE if stop_pending, else CMP_START.
- DUMP_START:
  - dump_start=1 for exactly this cycle, grant_dump=1, watchdog cleared.
  - Next state DUMP_WAIT. The dumper reads bank rd_bank, i.e. the data just produced.
- DUMP_WAIT:
  - grant_dump stays 1.
  - dump_done -> frame_count+1, grant_dump=0; next IDLE if stop_pending, else CMP_START.
  - Watchdog behaves as in CMP_WAIT.
- ERROR:
  - err=1, grant_dump=0, no pulses.
  - Held until rst; start is ignored.
- Address mux: bram_rd_addr = grant_dump ? dump_addr : cmp_addr, combinational from the registered grant_dump.
- stop:
  - A stop pulse in any non-IDLE, non-ERROR state sets stop_pending.
  - It takes effect only at a step boundary (end of SWAP without a dump, or end of DUMP_WAIT).
  - It never aborts a sweep or a dump in progress.
- Ignored inputs:
  - start while busy.
  - cmp_done outside CMP_WAIT.
  - dump_done outside DUMP_WAIT.
- Simultaneous events:
  - stop and cmp_done in the same CMP_WAIT cycle: the stop is registered and honoured at the SWAP.
  - stop and dump_done in the same cycle: go to IDLE.
- rst mid-operation: immediate return to reset values. Any sweep or dump in flight is abandoned; upstream blocks are reset by the same rst.

Test Plan:
- cfg_frame_div=3, start, cmp_done 20 cycles after each cmp_start, dump_done 30 cycles after dump_start, stop after the 6th step -> dump_start after steps 3 and 6 only; rd_bank toggles 6 times and ends 0; step_count=6, frame_count=2; returns to IDLE.
- cfg_frame_div=0 -> treated as 1: dump_start after every step; step_count equals frame_count at each IDLE/CMP_START.
- Drive cmp_addr=0x123, dump_addr=0x9C3 -> bram_rd_addr=0x123 in CMP_WAIT and 0x9C3 during DUMP_START/DUMP_WAIT.
- TIMEOUT=16, cmp_done withheld -> err=1 and state ERROR after 16 cycles in CMP_WAIT; a later start is ignored; rst clears err.
- stop pulsed in CMP_WAIT together with cmp_done, div=2, step_count=0 -> SWAP, then IDLE; no dump_start; step_count=1.
- rst asserted in DUMP_WAIT -> next cycle grant_dump=0, busy=0, counters 0, rd_bank 0; a stray dump_done afterwards has no effect.
